// File: rtl/seg_digit_scheduler.sv
// Time-multiplexed hex display driver: one shared 7-segment bus, one-hot digit
// enables, blanking gap after each digit, and a shadow/active register pair
// so that new values take effect only at frame boundaries.
module seg_digit_scheduler #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   active_q, active_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic [6:0]          segments_q, segments_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                frame_start_q, frame_start_d;
  logic                boundary_c;

  // Hex nibble to active-high segment pattern (bit0=a .. bit6=g).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Shadow register is free whenever no value is waiting for a frame boundary.
  assign wr_ready = ~pending_q;

  // Next-state, register transfer and registered-output decode.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    boundary_c    = 1'b0;
    segments_d    = 7'h00;
    digit_en_d    = '0;
    frame_start_d = 1'b0;

    if (!ena) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_SHOW;
          idx_d      = '0;
          cnt_d      = '0;
          boundary_c = 1'b1;
        end
        ST_SHOW: begin
          if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              idx_d      = '0;
              boundary_c = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Only a value pending before the boundary edge is promoted; a write
    // accepted on that same edge waits for the next boundary.
    if (boundary_c && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (wr_valid && !pending_q) begin
      shadow_d  = wr_data;
      pending_d = 1'b1;
    end

    frame_start_d = boundary_c;
    if (state_d == ST_SHOW) begin
      digit_en_d = NUM_DIGITS'(1) << idx_d;
      segments_d = hex_to_seg(active_d[{idx_d, 2'b00} +: 4]);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      segments_q    <= 7'h00;
      digit_en_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      segments_q    <= segments_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign segments    = segments_q;
  assign digit_en    = digit_en_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_digit_scheduler.sv
// Scoreboard bench for seg_digit_scheduler with 4 digits, dwell 4, blank 2.
module tb_seg_digit_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [6:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_on  = 1'b0;

  typedef struct {
    logic [3:0] den;
    logic [6:0] seg;
    logic       fs;
    int         gap;
  } exp_t;

  exp_t exp_q[$];

  seg_digit_scheduler #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(2),
    .CNT_W       (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .segments   (segments),
    .digit_en   (digit_en),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the next cycle showing frame_start, bounded.
  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 100);
    n_tests++;
    if (!frame_start) begin
      n_fail++;
      $display("FAIL wait_fs: got no frame_start expected one within 100 cycles");
    end
  endtask

  // Queue the expected digit starts of one frame (first ndig digits).
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input int ndig, input int first_gap);
    logic [6:0] segs [4];
    exp_t e;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int i = 0; i < ndig; i++) begin
      e.den = 4'(1 << i);
      e.seg = segs[i];
      e.fs  = (i == 0);
      e.gap = (i == 0) ? first_gap : 6;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pops an expectation at each digit start and checks idle/hold cycles.
  int   cyc = 0;
  int   last_start = 0;
  logic [3:0] prev_den = 4'h0;
  exp_t cur;
  always @(negedge clk) begin
    if (mon_on) begin
      cyc++;
      if (digit_en != 4'h0 && digit_en != prev_den) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_digit: got digit_en %0h seg %0h expected none", digit_en, segments);
        end else begin
          cur = exp_q.pop_front();
          chk("start_digit_en", 32'(digit_en), 32'(cur.den));
          chk("start_segments", 32'(segments), 32'(cur.seg));
          chk("start_frame_start", 32'(frame_start), 32'(cur.fs));
          if (cur.gap != 0) chk("start_gap", cyc - last_start, cur.gap);
        end
        last_start = cyc;
      end else if (digit_en != 4'h0) begin
        chk("hold_digit_en", 32'(digit_en), 32'(cur.den));
        chk("hold_segments", 32'(segments), 32'(cur.seg));
        chk("hold_frame_start", 32'(frame_start), 32'h0);
      end else begin
        chk("off_segments", 32'(segments), 32'h0);
        chk("off_frame_start", 32'(frame_start), 32'h0);
      end
      prev_den = digit_en;
    end
  end

  initial begin
    // Reset with a write offered; it must be ignored.
    rst_n    = 1'b0;
    ena      = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 16'hF9A0;
    tick(3);
    chk("rst_segments", 32'(segments), 32'h0);
    chk("rst_digit_en", 32'(digit_en), 32'h0);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h1);
    mon_on   = 1'b1;
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    tick(2);
    chk("post_rst_wr_ready", 32'(wr_ready), 32'h1);
    chk("idle_digit_en", 32'(digit_en), 32'h0);

    // 1: free-running with active=0.
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4, 0);
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4, 6);
    ena = 1'b1;
    wait_fs();
    wait_fs();

    // 2: mid-frame write of F9A0.
    tick(5);
    wr_valid = 1'b1;
    wr_data  = 16'hF9A0;
    tick(1);
    wr_valid = 1'b0;
    chk("s2_wr_ready_low", 32'(wr_ready), 32'h0);
    push_frame(7'h3F, 7'h77, 7'h6F, 7'h71, 4, 6);
    wait_fs();
    chk("s2_wr_ready_at_fs", 32'(wr_ready), 32'h1);

    // 3: valid held with changing data; only 1234 is taken.
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06, 4, 6);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (i == 0) chk("s3_wr_ready_low", 32'(wr_ready), 32'h0);
      wr_data = 16'h5678 + 16'(i * 16'h1111);
    end
    wr_valid = 1'b0;
    wait_fs();

    // 4: write accepted on the boundary edge shows one frame later.
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06, 4, 6);
    push_frame(7'h5E, 7'h4F, 7'h39, 7'h07, 3, 6);
    tick(23);
    chk("s4_pre_boundary_fs", 32'(frame_start), 32'h0);
    wr_valid = 1'b1;
    wr_data  = 16'h7C3D;
    tick(1);
    wr_valid = 1'b0;
    chk("s4_boundary_fs", 32'(frame_start), 32'h1);
    chk("s4_wr_ready_low", 32'(wr_ready), 32'h0);
    wait_fs();

    // 5: ena dropped during digit 2.
    tick(13);
    chk("s5_digit2_on", 32'(digit_en), 32'h4);
    ena = 1'b0;
    tick(1);
    chk("s5_off_digit_en", 32'(digit_en), 32'h0);
    chk("s5_off_segments", 32'(segments), 32'h0);
    push_frame(7'h5E, 7'h4F, 7'h39, 7'h07, 1, 0);
    tick(3);
    ena = 1'b1;
    tick(1);
    chk("s5_reen_digit_en", 32'(digit_en), 32'h1);
    chk("s5_reen_fs", 32'(frame_start), 32'h1);

    // 6: one-cycle reset mid-blank with a pending write.
    wr_valid = 1'b1;
    wr_data  = 16'h1111;
    tick(1);
    wr_valid = 1'b0;
    chk("s6_pending", 32'(wr_ready), 32'h0);
    tick(3);
    chk("s6_in_blank", 32'(digit_en), 32'h0);
    rst_n = 1'b0;
    tick(1);
    chk("s6_rst_segments", 32'(segments), 32'h0);
    chk("s6_rst_digit_en", 32'(digit_en), 32'h0);
    chk("s6_rst_fs", 32'(frame_start), 32'h0);
    chk("s6_rst_wr_ready", 32'(wr_ready), 32'h1);
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4, 0);
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4, 6);
    rst_n = 1'b1;
    wait_fs();
    wait_fs();
    tick(20);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_digit_scheduler.md
Name: seg_digit_scheduler

Overview:
Time-multiplexes NUM_DIGITS hex digits onto one shared 7-segment bus with one-hot digit enables. Each digit is shown for a fixed dwell time, then a blanking gap removes ghosting. New display values come in through a valid/ready port into a shadow register. The shadow register is copied to the active register only at a frame boundary, so a frame never shows a mix of old and new digits. The block sits between the seconds/counter logic and uo_out/uio_out in the top level.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
DWELL_CYCLES, 1000, clocks each digit is driven (>=1)
BLANK_CYCLES, 16, clocks of all-off gap after each digit (>=1)
CNT_W, 10, phase counter width; must hold max(DWELL_CYCLES, BLANK_CYCLES)-1

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
ena  in  1  design enable; low forces idle
wr_valid  in  1  new display value offered
wr_ready  out  1  shadow register free; equals ~pending
wr_data  in  4*NUM_DIGITS  hex nibbles, digit0 = bits[3:0]
segments  out  7  active-high segments, bit0=a .. bit6=g
digit_en  out  NUM_DIGITS  one-hot active-high digit select
frame_start  out  1  1-cycle pulse on entry to SHOW for digit 0

Behaviour:
- Reset is sampled only on a clk edge while rst_n=0.
- Reset values: state=IDLE, idx=0, cnt=0, active=0, shadow=0, pending=0.
- Outputs in reset: segments=0, digit_en=0, frame_start=0.
- wr_ready is combinational ~pending, so it reads 1 after reset; writes during reset are ignored.
- All display outputs are registered and reflect the current state; there is no combinational path from any input to any output except wr_ready.
- Accept: wr_valid & wr_ready -> shadow<=wr_data, pending<=1.
- FSM states: IDLE, SHOW, BLANK.
- IDLE:
  - segments=0, digit_en=0.
  - ena=1 -> next cycle enters SHOW with idx=0 and cnt=0. This is a frame boundary: frame_start=1 in that cycle.
- SHOW:
  - digit_en[idx]=1, all other bits 0; segments=decode(active[idx]).
  - cnt increments each cycle.
  - When cnt==DWELL_CYCLES-1: go to BLANK, cnt<=0.
- BLANK:
  - segments=0, digit_en=0; cnt increments.
  - When cnt==BLANK_CYCLES-1: go to SHOW, cnt<=0.
  - idx<=idx+1, wrapping NUM_DIGITS-1 -> 0. A wrap is a frame boundary: frame_start=1 in that first SHOW cycle.
- Frame boundary transfer: on the edge entering SHOW for idx 0 (from BLANK or from IDLE), if pending was 1 before that edge, then active<=shadow and pending<=0.
- Simultaneous accept and boundary: a write accepted on the same edge is not transferred. It stays pending until the next boundary.
- ena deassert in any state -> next cycle IDLE, idx=0, cnt=0, outputs 0. active, shadow and pending are retained, and writes are still accepted.
- Frame period = NUM_DIGITS*(DWELL_CYCLES+BLANK_CYCLES) clocks.
- Decode table (hex): 0->3F, 1->06, 2->5B, 3->4F, 4->66, 5->6D, 6->7D, 7->07, 8->7F, 9->6F, A->77, b->7C, C->39, d->5E, E->79, F->71.
- Reset mid-frame: next cycle all outputs 0 and state IDLE. The pending write is discarded.

Test Plan:
All scenarios use NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2, giving a 24-cycle frame.
1. Reset then ena=1, no writes:
   - frame_start pulses every 24 cycles.
   - digit_en shows 0001 for 4 cycles, then 0000 for 2, then 0010, 0100, 1000 in the same pattern.
   - segments=3F during each SHOW, 00 during BLANK.
2. Write 16'hF9A0 mid-frame:
   - wr_ready drops the next cycle; the current frame still shows 3F on all digits.
   - The next frame shows 3F, 77, 6F, 71 on digits 0..3.
   - wr_ready returns to 1 on the frame-start cycle.
3. wr_valid held high with changing data while pending=1:
   - No further accepts occur; only the first value is displayed.
4. Write accepted on the exact frame-boundary edge:
   - The display is unchanged for that frame; the new value appears one frame (24 cycles) later.
5. ena dropped during the SHOW of digit 2:
   - The next cycle has digit_en=0 and segments=0.
   - When ena is raised again, the next cycle has digit_en=0001 and frame_start=1.
6. rst_n=0 for one cycle mid-BLANK with pending=1:
   - All outputs go to 0 and wr_ready=1.
   - After ena=1 the display shows 3F on every digit (active reset to 0).
